ram_responder: RTL and testbench

Memory-side responder for the control unit's MFA/MOC handshake. It accepts one access request at a time from the datapath: read or write, in byte, halfword or word size. It performs the access on a byte-addressable, big-endian memory array after a programmable latency, then asserts MOC to release the control unit from its memory-wait state. It sits between the datapath (MAR/MDR) and main memory and is the counterpart of the next-state decoder's MOC wait loop.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/ram_byte_array.sv | 37 +++
 rtl/ram_responder.sv | 158 +++++++++++++++
 tb/tb_ram_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-access codes, responder states and alignment helper
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10
  } resp_state_e;

  // Reserved size and misaligned halfword/word accesses are rejected.
  function automatic logic access_ok(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: access_ok = 1'b1;
      SZ_HALF: access_ok = (addr_lo[0] == 1'b0);
      SZ_WORD: access_ok = (addr_lo == 2'b00);
      default: access_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ram_byte_array.sv
// rtl/ram_byte_array.sv - byte-wide array with four consecutive-byte lanes
// Lane 0 (we[3], bits 31:24) is the byte at addr; lane addresses wrap at the array end.
module ram_byte_array #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [7:0]            mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] lane_addr [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = addr + ADDR_WIDTH'(i);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[3-i]) begin
        mem[lane_addr[i]] <= wdata[8*(3-i) +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) begin
      rdata[8*(3-i) +: 8] = mem[lane_addr[i]];
    end
  end

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - MFA/MOC memory responder with programmable latency
// Big-endian byte/halfword/word accesses; rejected accesses complete with Err=1.
module ram_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MFA,
  input  logic        RW,
  input  logic [1:0]  Size,
  input  logic        Signed,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        Err
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  resp_state_e           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [31:0]           din_q, din_d;
  logic                  moc_q, moc_d;
  logic                  err_q, err_d;
  logic [31:0]           dout_q, dout_d;

  logic [3:0]  lane_we;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] rd_ext;
  logic        req_ok;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^Address[31:ADDR_WIDTH];

  ram_byte_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .addr  (addr_q),
    .we    (mem_we),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign req_ok = access_ok(size_q, addr_q[1:0]);

  // Sub-word data is left-justified onto the lanes starting at the request address.
  always_comb begin
    lane_we   = 4'b1111;
    mem_wdata = din_q;
    rd_ext    = mem_rdata;
    case (size_q)
      SZ_BYTE: begin
        lane_we   = 4'b1000;
        mem_wdata = {din_q[7:0], 24'h0};
        rd_ext    = {{24{signed_q & mem_rdata[31]}}, mem_rdata[31:24]};
      end
      SZ_HALF: begin
        lane_we   = 4'b1100;
        mem_wdata = {din_q[15:0], 16'h0};
        rd_ext    = {{16{signed_q & mem_rdata[31]}}, mem_rdata[31:16]};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    size_d   = size_q;
    signed_d = signed_q;
    din_d    = din_q;
    moc_d    = moc_q;
    err_d    = err_q;
    dout_d   = dout_q;
    mem_we   = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (MFA) begin
          addr_d   = Address[ADDR_WIDTH-1:0];
          rw_d     = RW;
          size_d   = Size;
          signed_d = Signed;
          din_d    = DataIn;
          cnt_d    = CNT_LOAD;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!MFA) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
          moc_d   = 1'b1;
          err_d   = !req_ok;
          if (rw_q == RW_READ) begin
            dout_d = req_ok ? rd_ext : 32'h0;
          end else if (req_ok) begin
            mem_we = reset ? 4'b0000 : lane_we;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        if (!MFA) begin
          state_d = ST_IDLE;
          moc_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rw_q     <= RW_READ;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      din_q    <= '0;
      moc_q    <= 1'b0;
      err_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      din_q    <= din_d;
      moc_q    <= moc_d;
      err_q    <= err_d;
      dout_q   <= dout_d;
    end
  end

  assign DataOut = dout_q;
  assign MOC     = moc_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - directed self-checking bench for ram_responder
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MFA = 1'b0;
  logic        RW = 1'b1;
  logic [1:0]  Size = 2'b00;
  logic        Signed = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] DataIn = '0;
  logic [31:0] DataOut;
  logic        MOC;
  logic        Err;

  int checks = 0;
  int errors = 0;

  int          lat;
  logic [31:0] dout;
  logic        err;
  logic        moc_after;

  always #5 clk = ~clk;

  ram_responder #(.ADDR_WIDTH(9), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .MFA(MFA), .RW(RW), .Size(Size), .Signed(Signed),
    .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MOC(MOC), .Err(Err)
  );

  // Full handshake: lat = edges from capture to MOC (-1 on timeout), moc_low = MOC after dropping MFA.
  task automatic access(input logic rw, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lt, output logic [31:0] dv, output logic ev, output logic moc_low);
    @(negedge clk);
    MFA = 1'b1; RW = rw; Size = sz; Signed = sg; Address = a; DataIn = d;
    @(posedge clk);
    lt = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (MOC === 1'b1) begin lt = k; break; end
    end
    dv = DataOut; ev = Err;
    @(negedge clk);
    MFA = 1'b0; RW = ~rw; Address = 32'hA5A5_A5A5; DataIn = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    moc_low = MOC;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++; if (MOC !== 1'b0) begin errors++; $display("FAIL reset_moc got %b exp 0", MOC); end
    checks++; if (Err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", Err); end
    checks++; if (DataOut !== 32'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", DataOut); end
  endtask

  task automatic test_word();
    logic [7:0] exp_b [4];
    exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    access(1'b0, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, lat, dout, err, moc_after);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_word_latency got %0d exp 2", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_word_err got %b exp 0", err); end
    checks++; if (moc_after !== 1'b0) begin errors++; $display("FAIL wr_word_moc_drop got %b exp 0", moc_after); end
    access(1'b1, 2'b10, 1'b0, 32'h010, 32'h0, lat, dout, err, moc_after);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_word_latency got %0d exp 2", lat); end
    checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_word_data got %h exp deadbeef", dout); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_word_err got %b exp 0", err); end
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 2'b00, 1'b0, 32'h010 + i, 32'h0, lat, dout, err, moc_after);
      checks++;
      if (dout !== {24'h0, exp_b[i]}) begin
        errors++; $display("FAIL rd_byte_%0d got %h exp %h", i, dout, {24'h0, exp_b[i]});
      end
    end
  endtask

  task automatic test_extension();
    access(1'b1, 2'b00, 1'b1, 32'h012, 32'h0, lat, dout, err, moc_after);
    checks++; if (dout !== 32'hFFFFFFBE) begin errors++; $display("FAIL byte_signed got %h exp ffffffbe", dout); end
    access(1'b1, 2'b00, 1'b0, 32'h012, 32'h0, lat, dout, err, moc_after);
    checks++; if (dout !== 32'h000000BE) begin errors++; $display("FAIL byte_unsigned got %h exp 000000be", dout); end
    access(1'b1, 2'b01, 1'b1, 32'h010, 32'h0, lat, dout, err, moc_after);
    checks++; if (dout !== 32'hFFFFDEAD) begin errors++; $display("FAIL half_signed got %h exp ffffdead", dout); end
    access(1'b1, 2'b01, 1'b0, 32'h012, 32'h0, lat, dout, err, moc_after);
    checks++; if (dout !== 32'h0000BEEF) begin errors++; $display("FAIL half_unsigned got %h exp 0000beef", dout); end
    access(1'b1, 2'b10, 1'b1, 32'h010, 32'h0, lat, dout, err, moc_after);
    checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL word_signed_ignored got %h exp deadbeef", dout); end
  endtask

  task automatic test_subword();
    access(1'b0, 2'b01, 1'b0, 32'h012, 32'hFFFF1234, lat, dout, err, moc_after);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL half_write_err got %b exp 0", err); end
    access(1'b1, 2'b10, 1'b0, 32'h010, 32'h0, lat, dout, err, moc_after);
    checks++; if (dout !== 32'hDEAD1234) begin errors++; $display("FAIL half_write_merge got %h exp dead1234", dout); end
    access(1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0000005A, lat, dout, err, moc_after);
    access(1'b1, 2'b00, 1'b0, 32'h000001FF, 32'h0, lat, dout, err, moc_after);
    checks++; if (dout !== 32'h0000005A) begin errors++; $display("FAIL top_byte_wrap got %h exp 0000005a", dout); end
    access(1'b1, 2'b00, 1'b0, 32'h000001FE, 32'h0, lat, dout, err, moc_after);
    access(1'b1, 2'b01, 1'b0, 32'h000001FE, 32'h0, lat, dout, err, moc_after);
    checks++; if (dout[7:0] !== 8'h5A) begin errors++; $display("FAIL top_half_low got %h exp 5a", dout[7:0]); end
  endtask

  task automatic test_misaligned();
    access(1'b0, 2'b10, 1'b0, 32'h011, 32'h01020304, lat, dout, err, moc_after);
    checks++; if (lat !== 2) begin errors++; $display("FAIL misalign_wr_moc got %0d exp 2", lat); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL misalign_wr_err got %b exp 1", err); end
    checks++; if (moc_after !== 1'b0) begin errors++; $display("FAIL misalign_err_clear got %b exp 0", moc_after); end
    checks++; if (Err !== 1'b0) begin errors++; $display("FAIL misalign_err_drop got %b exp 0", Err); end
    access(1'b1, 2'b10, 1'b0, 32'h010, 32'h0, lat, dout, err, moc_after);
    checks++; if (dout !== 32'hDEAD1234) begin errors++; $display("FAIL misalign_no_write got %h exp dead1234", dout); end
    access(1'b1, 2'b01, 1'b1, 32'h013, 32'h0, lat, dout, err, moc_after);
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL misalign_rd_data got %h exp 0", dout); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL misalign_rd_err got %b exp 1", err); end
    access(1'b1, 2'b10, 1'b0, 32'h010, 32'h0, lat, dout, err, moc_after);
    access(1'b1, 2'b11, 1'b0, 32'h010, 32'h0, lat, dout, err, moc_after);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rsvd_size_err got %b exp 1", err); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL rsvd_size_data got %h exp 0", dout); end
  endtask

  task automatic test_ack_hold();
    int held;
    @(negedge clk);
    MFA = 1'b1; RW = 1'b1; Size = 2'b10; Signed = 1'b0; Address = 32'h010;
    @(posedge clk);
    for (int k = 0; k < 20 && MOC !== 1'b1; k++) begin @(posedge clk); #1; end
    @(negedge clk);
    Address = 32'h014; Size = 2'b00; RW = 1'b0;
    held = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (MOC === 1'b1 && DataOut === 32'hDEAD1234) held++;
    end
    checks++; if (held !== 5) begin errors++; $display("FAIL ack_hold got %0d cycles exp 5", held); end
    @(negedge clk); MFA = 1'b0;
    @(posedge clk); #1;
    checks++; if (MOC !== 1'b0) begin errors++; $display("FAIL ack_release got %b exp 0", MOC); end
    checks++; if (DataOut !== 32'hDEAD1234) begin errors++; $display("FAIL dout_hold got %h exp dead1234", DataOut); end
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    MFA = 1'b1; RW = 1'b0; Size = 2'b10; Address = 32'h010; DataIn = 32'h11111111;
    @(posedge clk);
    @(negedge clk); MFA = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (MOC === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_moc got %0d exp 0", seen); end
    access(1'b1, 2'b10, 1'b0, 32'h010, 32'h0, lat, dout, err, moc_after);
    checks++; if (dout !== 32'hDEAD1234) begin errors++; $display("FAIL abort_no_write got %h exp dead1234", dout); end
  endtask

  task automatic test_reset_wait();
    access(1'b0, 2'b10, 1'b0, 32'h020, 32'h11223344, lat, dout, err, moc_after);
    @(negedge clk);
    MFA = 1'b1; RW = 1'b0; Size = 2'b10; Address = 32'h020; DataIn = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0; MFA = 1'b0;
    checks++; if (MOC !== 1'b0) begin errors++; $display("FAIL rst_wait_moc got %b exp 0", MOC); end
    checks++; if (DataOut !== 32'h0) begin errors++; $display("FAIL rst_wait_dout got %h exp 0", DataOut); end
    access(1'b1, 2'b10, 1'b0, 32'h020, 32'h0, lat, dout, err, moc_after);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rst_wait_idle got %0d exp 2", lat); end
    checks++; if (dout !== 32'h11223344) begin errors++; $display("FAIL rst_wait_no_write got %h exp 11223344", dout); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_extension();
    test_subword();
    test_misaligned();
    test_ack_hold();
    test_abort();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
